// File: rtl/rv32i_memarb.sv
// rv32i_memarb: shares one registered-read memory port between fetch and data.
// Data wins conflicts; a starvation counter forces a fetch win after STARVE_MAX losses.
module rv32i_memarb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [29:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [3:0]  i_d_be,
  input  logic [29:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [29:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [3:0]  o_starve_cnt
);
  localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);
  logic [3:0] r_starve;
  logic       r_rd_if;
  logic       r_rd_d;
  logic       w_if_win;
  logic       w_ig;
  logic       w_dg;
  logic       w_lost;
  // Grants are gated by reset so nothing reaches memory while reset is held.
  always_comb begin
    w_if_win    = i_if_req & (~i_d_req | (r_starve == LP_MAX));
    w_ig        = i_rst_n & w_if_win;
    w_dg        = i_rst_n & i_d_req & ~w_if_win;
    w_lost      = w_dg & i_if_req;
    o_if_gnt    = w_ig;
    o_d_gnt     = w_dg;
    o_mem_en    = w_ig | w_dg;
    o_mem_we    = w_dg & i_d_we;
    o_mem_be    = w_dg ? i_d_be : (w_ig ? 4'hF : 4'h0);
    o_mem_addr  = w_dg ? i_d_addr : (w_ig ? i_if_addr : 30'd0);
    o_mem_wdata = w_dg ? i_d_wdata : 32'd0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= 4'd0;
      r_rd_if  <= 1'b0;
      r_rd_d   <= 1'b0;
    end else begin
      r_starve <= w_ig ? 4'd0 : (w_lost ? r_starve + 4'd1 : r_starve);
      r_rd_if  <= w_ig;
      r_rd_d   <= w_dg & ~i_d_we;
    end
  end
  assign o_if_rvalid  = r_rd_if;
  assign o_d_rvalid   = r_rd_d;
  assign o_if_rdata   = i_mem_rdata;
  assign o_d_rdata    = i_mem_rdata;
  assign o_starve_cnt = r_starve;
endmodule

// File: doc/rv32i_memarb.md
# rv32i_memArb

Two-port to one-port memory arbiter for the RV32I core. It shares the single registered-read memory interface between instruction fetch (IF stage) and data access (MEM stage loads/stores). Requests are granted in the same cycle. Read data is returned one cycle later to the requester that owned the access. Data accesses have priority over fetch, and a starvation counter guarantees fetch forward progress.

## Interface
Parameters:
- STARVE_MAX, default 4: number of consecutive cycles fetch may lose a conflict before it is forced to win one; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- if_req  in  1  fetch request.
- if_addr  in  30  fetch word address [31:2].
- if_gnt  out  1  fetch access accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  30  data word address [31:2].
- d_wdata  in  32  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid; never asserted for stores.
- d_rdata  out  32  load data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  30  memory word address [31:2].
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read is issued.

## Operation
- **Arbitration** is combinational within the cycle.
  - Only one requester: it is granted.
  - Both requesting: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- **Grant rules**
  - Exactly one of if_gnt/d_gnt may be high per cycle.
  - A grant is never issued without the matching req.
- **Memory drive**
  - mem_en = if_gnt | d_gnt.
  - mem_addr, mem_we, mem_be and mem_wdata come from the granted requester.
  - Fetch grant drives mem_we = 0 and mem_be = 4'hF.
  - No grant drives mem_en = 0, mem_we = 0, mem_be = 0, and addr/wdata = 0.
- **starve_cnt** (4-bit register)
  - Increments when both requests are high and data wins.
  - Clears to 0 whenever fetch is granted.
  - Holds otherwise, including when fetch is idle.
- **Response tracking:** a registered 2-bit owner field {rd_if, rd_d} is loaded each cycle.
  - rd_if = if_gnt.
  - rd_d = d_gnt & ~d_we.
  - if_rvalid = rd_if and d_rvalid = rd_d.
  - if_rdata and d_rdata are both driven from mem_rdata; consumers qualify with rvalid.
- **Requester contract**
  - A requester holds req and its payload stable until it sees gnt.
  - It may drop req or change the address in the cycle after gnt.
  - Back-to-back accesses are allowed: one access per cycle, fully pipelined.
- **Reset**
  - While reset = 0: starve_cnt = 0, rd_if = rd_d = 0, and all gnt and mem_en outputs are forced to 0.
  - Reset asserted mid-access discards the in-flight response; no rvalid is issued after release.

## Timing
- Grant latency is 0 cycles; the memory is addressed in the same cycle req is seen.
- Read latency is 1 cycle: an access granted in cycle N has rvalid high in cycle N+1 with mem_rdata.
- Store completes at the grant edge and produces no response.
- Simultaneous conflict: worst-case fetch wait is STARVE_MAX cycles, with the grant in cycle STARVE_MAX+1 of a continuous conflict.
- Reset deassertion is synchronised by the system. The first grant is possible in the first cycle with reset = 1.
- Reset values after assertion: if_gnt = 0, d_gnt = 0, if_rvalid = 0, d_rvalid = 0, mem_en = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.

## Test plan
- **Fetch only:** if_req = 1 for 3 cycles at addrs 0, 1, 2.
  - if_gnt is high each cycle and mem_addr = 0, 1, 2.
  - if_rvalid is high in cycles 2–4 with matching mem_rdata; d_rvalid stays 0.
- **Single conflict:** if_req = d_req = 1 (load at 0x10) for one cycle.
  - d_gnt = 1 and if_gnt = 0.
  - Next cycle, with fetch alone: if_gnt = 1.
  - d_rvalid pulses in the cycle after the load grant, and if_rvalid pulses one cycle later.
- **Starvation** (STARVE_MAX = 4): both requests held for 6 cycles.
  - Grant pattern is d, d, d, d, if, d.
  - starve_cnt reads 1, 2, 3, 4, 0, 1.
- **Store:** d_req = 1, d_we = 1, d_be = 4'b0011, d_wdata = 0xDEADBEEF.
  - mem_we = 1 and mem_be = 0011 with the data on mem_wdata.
  - d_rvalid stays 0 the next cycle.
- **Reset mid-access:** grant a load, then drive reset = 0 asynchronously before the next edge.
  - d_rvalid, d_gnt and mem_en drop immediately.
  - After release, no stale rvalid appears and starve_cnt = 0.
